// File: rtl/wb_cmd_bridge_pkg.sv
// Shared definitions for the byte-stream to Wishbone command bridge and the
// glitch register map it drives.
package wb_cmd_bridge_pkg;

  // Command byte layout: bit 7 selects write, low bits carry the address.
  localparam int unsigned CMD_WE_BIT = 7;

  // Response bytes returned for non-read completions.
  localparam logic [7:0] RESP_WR_OK   = 8'h00;
  localparam logic [7:0] RESP_TIMEOUT = 8'hEE;

  // Glitch register slave address map.
  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_WIDTH  = 4'h1;
  localparam logic [3:0] REG_DELAY0 = 4'h2;
  localparam logic [3:0] REG_DELAY1 = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GET_DATA = 2'd1,
    ST_WB_REQ   = 2'd2,
    ST_TX_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/wb_cmd_bridge.sv
// Byte-stream to Wishbone master bridge. Each command byte (plus one data
// byte for writes) becomes a single Wishbone cycle; one response byte is
// returned per command.
// Optional feature: define WB_CMD_TIMEOUT_EN to abort an unacknowledged
// cycle after TIMEOUT_CYCLES clocks (sets err_o, responds 0xEE).
module wb_cmd_bridge
  import wb_cmd_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              err_o
);

  state_t            r_state;
  logic              r_is_wr;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic              r_we;
  logic              r_stb;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_overrun;
  logic              w_rx_drop;

  // Command bits between the address field and the write flag are don't-care.
  logic              w_unused_cmd;
  assign w_unused_cmd = ^rx_data_i[CMD_WE_BIT-1:ADDR_W];

`ifdef WB_CMD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
`else
  logic             w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Bytes arriving while a cycle or response is outstanding are lost.
  assign w_rx_drop = rx_valid_i && ((r_state == ST_WB_REQ) || (r_state == ST_TX_RESP));

  // Command FSM with registered Wishbone and response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_is_wr    <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_we       <= 1'b0;
      r_stb      <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef WB_CMD_TIMEOUT_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      if (w_rx_drop) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (rx_valid_i) begin
            r_adr   <= rx_data_i[ADDR_W-1:0];
            r_is_wr <= rx_data_i[CMD_WE_BIT];
            if (rx_data_i[CMD_WE_BIT]) begin
              r_state <= ST_GET_DATA;
            end else begin
              r_state <= ST_WB_REQ;
              r_stb   <= 1'b1;
              r_we    <= 1'b0;
`ifdef WB_CMD_TIMEOUT_EN
              r_cnt   <= '0;
`endif
            end
          end
        end
        ST_GET_DATA: begin
          if (rx_valid_i) begin
            r_dat   <= rx_data_i;
            r_state <= ST_WB_REQ;
            r_stb   <= 1'b1;
            r_we    <= 1'b1;
`ifdef WB_CMD_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        ST_WB_REQ: begin
          // Only the first ack counts; stb drops at this edge so re-acks land outside WB_REQ.
          if (wb_ack_i) begin
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_tx_data  <= r_is_wr ? RESP_WR_OK : wb_dat_i;
            r_tx_valid <= 1'b1;
            r_state    <= ST_TX_RESP;
          end
`ifdef WB_CMD_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b1;
            r_tx_data  <= RESP_TIMEOUT;
            r_tx_valid <= 1'b1;
            r_state    <= ST_TX_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        ST_TX_RESP: begin
          if (tx_ready_i) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wb_adr_o   = r_adr;
  assign wb_dat_o   = r_dat;
  assign wb_we_o    = r_we;
  assign wb_stb_o   = r_stb;
  assign tx_data_o  = r_tx_data;
  assign tx_valid_o = r_tx_valid;
  assign busy_o     = (r_state != ST_IDLE);
  assign overrun_o  = r_overrun;
`ifdef WB_CMD_TIMEOUT_EN
  assign err_o      = r_err;
`else
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cmd_bridge.sv
// Directed bench for wb_cmd_bridge with a small glitch register slave model.
module tb_wb_cmd_bridge;
  import wb_cmd_bridge_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       slave_rst = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [3:0] wb_adr;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we;
  logic       wb_stb;
  logic       wb_ack;
  logic       busy;
  logic       overrun;
  logic       err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_cmd_bridge #(
    .ADDR_W(4),
    .DATA_W(8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_data_i(rx_data),
    .rx_valid_i(rx_valid),
    .tx_data_o(tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we),
    .wb_stb_o(wb_stb),
    .wb_ack_i(wb_ack),
    .busy_o(busy),
    .overrun_o(overrun),
    .err_o(err)
  );

  // Register slave: registered ack that repeats while stb is held.
  logic [7:0] mem [16];
  logic       ack_en = 1'b1;
  always @(posedge clk or posedge slave_rst) begin
    if (slave_rst) begin
      wb_ack <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else begin
      wb_ack <= wb_stb && ack_en;
      if (wb_stb && wb_ack && wb_we) mem[wb_adr] <= wb_dat_o;
    end
  end
  assign wb_dat_i = mem[wb_adr];

  typedef struct {
    logic [7:0] cmd;
    bit         has_dat;
    logic [7:0] dat;
    logic [3:0] adr;
    bit         we;
    logic [7:0] resp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_stb_low(input int limit, output int n);
    n = 0;
    while (wb_stb === 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake();
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    chk("hs_tx_valid", {31'b0, tx_valid}, 0);
    chk("hs_busy", {31'b0, busy}, 0);
  endtask

  task automatic run_cmd(input vec_t v);
    int n;
    send_byte(v.cmd);
    if (v.has_dat) begin
      chk("get_data_busy", {31'b0, busy}, 1);
      chk("get_data_stb", {31'b0, wb_stb}, 0);
      send_byte(v.dat);
    end
    chk("stb_latency", {31'b0, wb_stb}, 1);
    chk("adr", {28'b0, wb_adr}, {28'b0, v.adr});
    chk("we", {31'b0, wb_we}, {31'b0, v.we});
    if (v.has_dat) chk("wdat", {24'b0, wb_dat_o}, {24'b0, v.dat});
    wait_stb_low(200, n);
    chk("stb_cycles", n, 2);
    chk("tx_valid_rise", {31'b0, tx_valid}, 1);
    chk("tx_data", {24'b0, tx_data}, {24'b0, v.resp});
    chk("we_after", {31'b0, wb_we}, 0);
    handshake();
  endtask

  initial begin
    int n;
    vec_t v;

    vecs[0] = '{8'h81, 1'b1, 8'h40, 4'h1, 1'b1, 8'h00};
    vecs[1] = '{8'h01, 1'b0, 8'h00, 4'h1, 1'b0, 8'h40};
    vecs[2] = '{8'h82, 1'b1, 8'h34, 4'h2, 1'b1, 8'h00};
    vecs[3] = '{8'h02, 1'b0, 8'h00, 4'h2, 1'b0, 8'h34};
    vecs[4] = '{8'hF3, 1'b1, 8'hA5, 4'h3, 1'b1, 8'h00};
    vecs[5] = '{8'h73, 1'b0, 8'h00, 4'h3, 1'b0, 8'hA5};
    vecs[6] = '{8'h8F, 1'b1, 8'hFF, 4'hF, 1'b1, 8'h00};
    vecs[7] = '{8'h0F, 1'b0, 8'h00, 4'hF, 1'b0, 8'hFF};
    vecs[8] = '{8'h80, 1'b1, 8'h01, 4'h0, 1'b1, 8'h00};
    vecs[9] = '{8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 8'h01};

    rst = 1'b1;
    slave_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stb", {31'b0, wb_stb}, 0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 0);
    chk("rst_outputs", {wb_adr, wb_dat_o, tx_data, wb_we, busy, overrun, err}, 0);
    rst = 1'b0;
    slave_rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_cmd(vecs[i]);
    chk("regmap_width", {24'b0, mem[REG_WIDTH]}, 32'h40);
    chk("regmap_delay0", {24'b0, mem[REG_DELAY0]}, 32'h34);
    chk("no_overrun_yet", {31'b0, overrun}, 0);
    chk("no_err_yet", {31'b0, err}, 0);

    // Backpressure on a read of delay_0.
    send_byte(8'h02);
    wait_stb_low(50, n);
    chk("bp_stb_cycles", n, 2);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", {31'b0, tx_valid}, 1);
      chk("bp_hold_data", {24'b0, tx_data}, 32'h34);
      @(posedge clk); #1;
    end
    chk("bp_busy_stall", {31'b0, busy}, 1);
    handshake();

    // GET_DATA waits indefinitely for the data byte.
    send_byte(8'h83);
    repeat (20) @(posedge clk);
    #1;
    chk("gd_wait_busy", {31'b0, busy}, 1);
    chk("gd_wait_stb", {31'b0, wb_stb}, 0);
    send_byte(8'h5A);
    wait_stb_low(50, n);
    chk("gd_tx_data", {24'b0, tx_data}, 32'h00);
    handshake();
    chk("gd_reg", {24'b0, mem[REG_DELAY1]}, 32'h5A);

    // Overrun: byte during WB_REQ is dropped, FSM unaffected.
    ack_en = 1'b0;
    send_byte(8'h01);
    send_byte(8'h55);
    chk("ovr_flag", {31'b0, overrun}, 1);
    chk("ovr_stb", {31'b0, wb_stb}, 1);
    chk("ovr_adr", {28'b0, wb_adr}, 1);
    chk("ovr_we", {31'b0, wb_we}, 0);
    ack_en = 1'b1;
    wait_stb_low(50, n);
    chk("ovr_tx_data", {24'b0, tx_data}, 32'h40);
    handshake();
    v = '{8'h02, 1'b0, 8'h00, 4'h2, 1'b0, 8'h34};
    run_cmd(v);
    chk("ovr_sticky", {31'b0, overrun}, 1);

    // Slave that never acks.
    ack_en = 1'b0;
    send_byte(8'h02);
`ifdef WB_CMD_TIMEOUT_EN
    wait_stb_low(50, n);
    chk("to_stb_cycles", n, 8);
    chk("to_err", {31'b0, err}, 1);
    chk("to_tx_valid", {31'b0, tx_valid}, 1);
    chk("to_tx_data", {24'b0, tx_data}, 32'hEE);
    handshake();
    send_byte(8'h02);
    repeat (2) @(posedge clk);
    #1;
`else
    wait_stb_low(120, n);
    chk("noto_stb_held", n, 120);
    chk("noto_err", {31'b0, err}, 0);
`endif
    chk("pre_rst_stb", {31'b0, wb_stb}, 1);
    chk("pre_rst_busy", {31'b0, busy}, 1);

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stb", {31'b0, wb_stb}, 0);
    chk("arst_tx_valid", {31'b0, tx_valid}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_overrun", {31'b0, overrun}, 0);
    chk("arst_err", {31'b0, err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ack_en = 1'b1;
    @(posedge clk); #1;
    v = '{8'h03, 1'b0, 8'h00, 4'h3, 1'b0, 8'h5A};
    run_cmd(v);
    chk("restart_overrun", {31'b0, overrun}, 0);

    // Byte arriving in the same cycle as the response handshake is dropped.
    send_byte(8'h01);
    wait_stb_low(50, n);
    chk("sim_tx_data", {24'b0, tx_data}, 32'h40);
    tx_ready = 1'b1;
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    chk("sim_overrun", {31'b0, overrun}, 1);
    chk("sim_busy", {31'b0, busy}, 0);
    chk("sim_tx_valid", {31'b0, tx_valid}, 0);
    @(posedge clk); #1;
    chk("sim_no_stb", {31'b0, wb_stb}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
